// File: rtl/udp_rx_parse.sv
// udp_rx_parse: parses an Ethernet II / IPv4 / UDP frame stream and emits the
// payload of frames addressed to the local MAC (or broadcast), IP and port.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   din/din_vld/din_sop/din_eop/din_mod   16-bit input frame stream
//   dout/dout_vld/dout_sop/dout_eop/dout_mod   16-bit payload stream (latency 1)
//   src_ip, src_port, pld_len  metadata of the frame currently being emitted
//   drop_cnt                   saturating count of dropped frames
//   trunc_err                  one-cycle pulse when a payload is cut short
module udp_rx_parse #(
  parameter logic [47:0] LOCAL_MAC  = 48'h000A_3501_FEC0,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0002,
  parameter logic [15:0] LOCAL_PORT = 16'd5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din,
  input  logic        din_vld,
  input  logic        din_sop,
  input  logic        din_eop,
  input  logic        din_mod,
  output logic [15:0] dout,
  output logic        dout_vld,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        dout_mod,
  output logic [31:0] src_ip,
  output logic [15:0] src_port,
  output logic [15:0] pld_len,
  output logic [15:0] drop_cnt,
  output logic        trunc_err
);

  localparam int unsigned WIDX_W = 5;
  localparam logic [WIDX_W-1:0] HDR_LAST = WIDX_W'(20);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PLD, S_DROP} state_t;

  state_t              state_q, state_d;
  logic [WIDX_W-1:0]   w_q, w_d, widx;
  logic                mac_loc_q, mac_loc_d, mac_loc_n;
  logic                mac_bc_q, mac_bc_d, mac_bc_n;
  logic                hdr_fail;
  logic [15:0]         rem_q, rem_d;
  logic                first_q, first_d;
  logic [31:0]         ip_sh_q, ip_sh_d;
  logic [15:0]         port_sh_q, port_sh_d;
  logic [15:0]         len_sh_q, len_sh_d;

  logic [15:0]         dout_d;
  logic                dout_vld_d, dout_sop_d, dout_eop_d, dout_mod_d, trunc_d;
  logic [31:0]         src_ip_d;
  logic [15:0]         src_port_d, pld_len_d, drop_cnt_d;
  logic [1:0]          drop_inc;
  logic [16:0]         drop_sum;

  logic hdr_go, hdr_end, abandon_hdr, pld_word, pld_last;

  // A sop word always restarts header parsing at word 0, whatever the state.
  assign widx        = din_sop ? '0 : w_q;
  assign hdr_go      = din_vld && (din_sop || (state_q == S_HDR));
  assign hdr_end     = hdr_go && (hdr_fail || din_eop);
  assign abandon_hdr = din_vld && din_sop && (state_q == S_HDR);
  assign pld_word    = din_vld && !din_sop && (state_q == S_PLD);
  assign pld_last    = rem_q <= 16'd2;

  // Header field checks; MAC match is tracked separately for local/broadcast
  // so a mix of the two across words is rejected.
  always_comb begin
    hdr_fail  = 1'b0;
    mac_loc_n = mac_loc_q;
    mac_bc_n  = mac_bc_q;
    case (widx)
      5'd0: begin
        mac_loc_n = (din == LOCAL_MAC[47:32]);
        mac_bc_n  = (din == 16'hFFFF);
        hdr_fail  = !(mac_loc_n || mac_bc_n);
      end
      5'd1: begin
        mac_loc_n = mac_loc_q && (din == LOCAL_MAC[31:16]);
        mac_bc_n  = mac_bc_q && (din == 16'hFFFF);
        hdr_fail  = !(mac_loc_n || mac_bc_n);
      end
      5'd2: begin
        mac_loc_n = mac_loc_q && (din == LOCAL_MAC[15:0]);
        mac_bc_n  = mac_bc_q && (din == 16'hFFFF);
        hdr_fail  = !(mac_loc_n || mac_bc_n);
      end
      5'd6:  hdr_fail = (din != 16'h0800);
      5'd7:  hdr_fail = (din[15:8] != 8'h45);
      5'd11: hdr_fail = (din[7:0] != 8'h11);
      5'd15: hdr_fail = (din != LOCAL_IP[31:16]);
      5'd16: hdr_fail = (din != LOCAL_IP[15:0]);
      5'd18: hdr_fail = (din != LOCAL_PORT);
      5'd19: hdr_fail = (din <= 16'd8);
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (hdr_go) begin
      if (hdr_fail)                state_d = din_eop ? S_IDLE : S_DROP;
      else if (din_eop)            state_d = S_IDLE;
      else if (widx == HDR_LAST)   state_d = S_PLD;
      else                         state_d = S_HDR;
    end else if (pld_word) begin
      if (pld_last)                state_d = din_eop ? S_IDLE : S_DROP;
      else if (din_eop)            state_d = S_IDLE;
    end else if (din_vld && din_eop && (state_q == S_DROP)) begin
      state_d = S_IDLE;
    end
  end

  // Output and datapath next values.
  always_comb begin
    w_d        = w_q;
    mac_loc_d  = mac_loc_q;
    mac_bc_d   = mac_bc_q;
    rem_d      = rem_q;
    first_d    = first_q;
    ip_sh_d    = ip_sh_q;
    port_sh_d  = port_sh_q;
    len_sh_d   = len_sh_q;
    dout_d     = dout;
    dout_vld_d = 1'b0;
    dout_sop_d = 1'b0;
    dout_eop_d = 1'b0;
    dout_mod_d = 1'b0;
    trunc_d    = 1'b0;
    src_ip_d   = src_ip;
    src_port_d = src_port;
    pld_len_d  = pld_len;

    if (hdr_go) begin
      w_d       = widx + WIDX_W'(1);
      mac_loc_d = mac_loc_n;
      mac_bc_d  = mac_bc_n;
      first_d   = 1'b0;
      case (widx)
        5'd13: ip_sh_d[31:16] = din;
        5'd14: ip_sh_d[15:0]  = din;
        5'd17: port_sh_d      = din;
        5'd19: begin
          rem_d    = din - 16'd8;
          len_sh_d = din - 16'd8;
        end
        5'd20: first_d = 1'b1;
        default: ;
      endcase
    end

    // New sop while forwarding: the cut frame gets no eop, only the pulse.
    if (din_vld && din_sop && (state_q == S_PLD)) trunc_d = 1'b1;

    if (pld_word) begin
      dout_d     = din;
      dout_vld_d = 1'b1;
      dout_sop_d = first_q;
      first_d    = 1'b0;
      if (first_q) begin
        src_ip_d   = ip_sh_q;
        src_port_d = port_sh_q;
        pld_len_d  = len_sh_q;
      end
      if (pld_last) begin
        dout_eop_d = 1'b1;
        dout_mod_d = (rem_q == 16'd1);
      end else if (din_eop) begin
        dout_eop_d = 1'b1;
        dout_mod_d = din_mod;
        trunc_d    = 1'b1;
      end else begin
        rem_d = rem_q - 16'd2;
      end
    end

    // An abandoned header and a failing new word 0 can both land in one cycle.
    drop_inc   = {1'b0, hdr_end} + {1'b0, abandon_hdr};
    drop_sum   = {1'b0, drop_cnt} + 17'(drop_inc);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q       <= '0;
      mac_loc_q <= 1'b0;
      mac_bc_q  <= 1'b0;
      rem_q     <= '0;
      first_q   <= 1'b0;
      ip_sh_q   <= '0;
      port_sh_q <= '0;
      len_sh_q  <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      dout_sop  <= 1'b0;
      dout_eop  <= 1'b0;
      dout_mod  <= 1'b0;
      src_ip    <= '0;
      src_port  <= '0;
      pld_len   <= '0;
      drop_cnt  <= '0;
      trunc_err <= 1'b0;
    end else begin
      w_q       <= w_d;
      mac_loc_q <= mac_loc_d;
      mac_bc_q  <= mac_bc_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      ip_sh_q   <= ip_sh_d;
      port_sh_q <= port_sh_d;
      len_sh_q  <= len_sh_d;
      dout      <= dout_d;
      dout_vld  <= dout_vld_d;
      dout_sop  <= dout_sop_d;
      dout_eop  <= dout_eop_d;
      dout_mod  <= dout_mod_d;
      src_ip    <= src_ip_d;
      src_port  <= src_port_d;
      pld_len   <= pld_len_d;
      drop_cnt  <= drop_cnt_d;
      trunc_err <= trunc_d;
    end
  end

endmodule

// File: tb/tb_udp_rx_parse.sv
// tb_udp_rx_parse: table-driven, directed and randomized checks of
// udp_rx_parse against a byte-level frame model.
module tb_udp_rx_parse;

  localparam logic [47:0] L_MAC  = 48'h000A_3501_FEC0;
  localparam logic [47:0] B_MAC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] L_IP   = 32'hC0A8_0002;
  localparam logic [15:0] L_PORT = 16'd5000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic        din_vld, din_sop, din_eop, din_mod;
  logic [15:0] dout;
  logic        dout_vld, dout_sop, dout_eop, dout_mod;
  logic [31:0] src_ip;
  logic [15:0] src_port, pld_len, drop_cnt;
  logic        trunc_err;

  always #5 clk = ~clk;

  udp_rx_parse dut (
    .clk(clk), .rst_n(rst_n),
    .din(din), .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop), .din_mod(din_mod),
    .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_mod(dout_mod), .src_ip(src_ip), .src_port(src_port), .pld_len(pld_len),
    .drop_cnt(drop_cnt), .trunc_err(trunc_err)
  );

  typedef struct {
    logic [15:0] d;
    logic        sop, eop, mod, tr;
    logic [31:0] ip;
    logic [15:0] port, len;
  } ow_t;

  typedef struct {
    logic [47:0] mac;
    logic [15:0] et;
    logic [7:0]  vi, proto;
    logic [31:0] dip;
    logic [15:0] dport, ulen;
    logic [39:0] pre;
    int          nbytes, gap, exp_words, exp_drop, exp_tr;
  } vec_t;

  ow_t        obs_q[$], exp_q[$];
  ow_t        mon_o;
  logic [7:0] fr[$];
  vec_t       tbl[16];
  int n_cmp = 0, n_bad = 0;
  int trunc_nv = 0;
  int exp_drop = 0;
  int tbl_drop = 0;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (dout_vld) begin
        mon_o.d = dout; mon_o.sop = dout_sop; mon_o.eop = dout_eop;
        mon_o.mod = dout_mod; mon_o.tr = trunc_err;
        mon_o.ip = src_ip; mon_o.port = src_port; mon_o.len = pld_len;
        obs_q.push_back(mon_o);
      end else if (trunc_err) begin
        trunc_nv++;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < 32'(p);
  endfunction

  function automatic logic [7:0] fb(input int i);
    return (i < fr.size()) ? fr[i] : 8'h00;
  endfunction

  task automatic build(input logic [47:0] mac, input logic [15:0] et, input logic [7:0] vi,
                       input logic [7:0] proto, input logic [31:0] dip, input logic [31:0] sip,
                       input logic [15:0] sport, input logic [15:0] dport, input logic [15:0] ulen,
                       input logic [39:0] pre, input int nbytes);
    logic [7:0] h[42];
    for (int i = 0; i < 42; i++) h[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) h[i] = mac[47-8*i -: 8];
    h[12] = et[15:8];  h[13] = et[7:0];
    h[14] = vi;        h[23] = proto;
    for (int i = 0; i < 4; i++) begin
      h[26+i] = sip[31-8*i -: 8];
      h[30+i] = dip[31-8*i -: 8];
    end
    h[34] = sport[15:8]; h[35] = sport[7:0];
    h[36] = dport[15:8]; h[37] = dport[7:0];
    h[38] = ulen[15:8];  h[39] = ulen[7:0];
    fr.delete();
    for (int i = 0; i < nbytes; i++) fr.push_back(i < 42 ? h[i] : 8'($urandom));
    if (pre != 40'd0)
      for (int i = 0; i < 5; i++) if (42 + i < nbytes) fr[42+i] = pre[39-8*i -: 8];
  endtask

  // Expected payload words for the frame in fr of nbytes bytes.
  task automatic model(input int nbytes, output int nwords, output int ntr);
    logic [47:0] mac; logic [15:0] et, dport, ulen; logic [31:0] dip, sip;
    bit ok; int plen, avail, m, pw, n, lmod, tr;
    ow_t o;
    nwords = 0; ntr = 0;
    ok = (nbytes > 42);
    if (ok) begin
      mac   = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
      et    = {fr[12], fr[13]};
      sip   = {fr[26], fr[27], fr[28], fr[29]};
      dip   = {fr[30], fr[31], fr[32], fr[33]};
      dport = {fr[36], fr[37]};
      ulen  = {fr[38], fr[39]};
      ok = (mac == L_MAC || mac == B_MAC) && et == 16'h0800 && fr[14] == 8'h45 &&
           fr[23] == 8'h11 && dip == L_IP && dport == L_PORT && ulen > 16'd8;
    end
    if (!ok) begin
      exp_drop++;
      return;
    end
    plen = int'(ulen) - 8; avail = nbytes - 42;
    m = (avail + 1) / 2;   pw = (plen + 1) / 2;
    if (pw <= m) begin n = pw; lmod = plen % 2;  tr = 0; end
    else         begin n = m;  lmod = avail % 2; tr = 1; end
    for (int k = 0; k < n; k++) begin
      o.d = {fb(42 + 2*k), fb(43 + 2*k)};
      o.sop = (k == 0); o.eop = (k == n - 1);
      o.mod = o.eop && (lmod == 1); o.tr = o.eop && (tr == 1);
      o.ip = sip; o.port = {fr[34], fr[35]}; o.len = 16'(plen);
      exp_q.push_back(o);
    end
    nwords = n; ntr = tr;
  endtask

  task automatic send(input int nbytes, input int nw, input int gap, input bit eop_en);
    int g;
    for (int i = 0; i < nw; i++) begin
      g = (gap == 1) ? ((i == 0) ? 0 : 1) : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin
        @(posedge clk); #1;
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_mod = 1'b0;
      end
      @(posedge clk); #1;
      din_vld = 1'b1;
      din[15:8] = (2*i < nbytes) ? fr[2*i] : 8'h00;
      din[7:0]  = (2*i + 1 < nbytes) ? fr[2*i+1] : 8'h00;
      din_sop = (i == 0);
      din_eop = eop_en && (i == nw - 1);
      din_mod = din_eop && (nbytes % 2 == 1);
    end
    @(posedge clk); #1;
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_mod = 1'b0;
  endtask

  task automatic flush();
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic cmp_out(input string tag);
    int n;
    chk({tag, " words"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s w%0d data/flags", tag, k),
          64'({obs_q[k].d, obs_q[k].sop, obs_q[k].eop, obs_q[k].mod, obs_q[k].tr}),
          64'({exp_q[k].d, exp_q[k].sop, exp_q[k].eop, exp_q[k].mod, exp_q[k].tr}));
      chk($sformatf("%s w%0d meta", tag, k),
          {obs_q[k].ip, obs_q[k].port, obs_q[k].len},
          {exp_q[k].ip, exp_q[k].port, exp_q[k].len});
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " stream"}, 64'({dout, dout_vld, dout_sop, dout_eop, dout_mod, trunc_err}), 64'd0);
    chk({tag, " meta"}, {src_ip, src_port, pld_len}, 64'd0);
    chk({tag, " drop_cnt"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    int nw, ntr, tr_obs, nv0, pl, nb, gp;
    logic [47:0] mac; logic [15:0] et, dport, ulen; logic [7:0] vi, proto; logic [31:0] dip;

    tbl[0]  = '{L_MAC, 16'h0800, 8'h45, 8'h11, L_IP, L_PORT, 16'd12, 40'hAABBCCDD00, 60, 0, 2, 0, 0};
    tbl[1]  = '{L_MAC, 16'h0800, 8'h45, 8'h11, L_IP, L_PORT, 16'd13, 40'h1122334455, 60, 0, 3, 0, 0};
    tbl[2]  = '{L_MAC, 16'h0800, 8'h45, 8'h11, L_IP, 16'd5001, 16'd12, 40'd0, 60, 0, 0, 1, 0};
    tbl[3]  = '{L_MAC, 16'h0806, 8'h45, 8'h11, L_IP, L_PORT, 16'd12, 40'd0, 60, 0, 0, 1, 0};
    tbl[4]  = '{L_MAC, 16'h0800, 8'h45, 8'h11, L_IP, L_PORT, 16'd8, 40'd0, 60, 0, 0, 1, 0};
    tbl[5]  = '{B_MAC, 16'h0800, 8'h45, 8'h11, L_IP, L_PORT, 16'd20, 40'd0, 62, 1, 6, 0, 0};
    tbl[6]  = '{L_MAC, 16'h0800, 8'h45, 8'h11, L_IP, L_PORT, 16'd100, 40'd0, 52, 0, 5, 0, 1};
    tbl[7]  = '{L_MAC, 16'h0800, 8'h45, 8'h11, L_IP, L_PORT, 16'd9, 40'd0, 60, 0, 1, 0, 0};
    tbl[8]  = '{L_MAC, 16'h0800, 8'h45, 8'h11, L_IP, L_PORT, 16'd12, 40'd0, 30, 0, 0, 1, 0};
    tbl[9]  = '{L_MAC, 16'h0800, 8'h45, 8'h11, 32'hC0A8_0003, L_PORT, 16'd12, 40'd0, 60, 0, 0, 1, 0};
    tbl[10] = '{L_MAC, 16'h0800, 8'h46, 8'h11, L_IP, L_PORT, 16'd12, 40'd0, 60, 0, 0, 1, 0};
    tbl[11] = '{L_MAC, 16'h0800, 8'h45, 8'h06, L_IP, L_PORT, 16'd12, 40'd0, 60, 0, 0, 1, 0};
    tbl[12] = '{48'h000A_FFFF_FFFF, 16'h0800, 8'h45, 8'h11, L_IP, L_PORT, 16'd12, 40'd0, 60, 0, 0, 1, 0};
    tbl[13] = '{L_MAC, 16'h0800, 8'h45, 8'h11, L_IP, L_PORT, 16'd30, 40'd0, 64, 2, 11, 0, 0};
    tbl[14] = '{L_MAC, 16'h0800, 8'h45, 8'h11, L_IP, L_PORT, 16'd12, 40'd0, 42, 0, 0, 1, 0};
    tbl[15] = '{L_MAC, 16'h0800, 8'h45, 8'h11, L_IP, L_PORT, 16'd14, 40'd0, 48, 0, 3, 0, 0};

    rst_n = 1'b0; din = '0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_mod = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Table-driven frames.
    for (int t = 0; t < 16; t++) begin
      nv0 = trunc_nv;
      build(tbl[t].mac, tbl[t].et, tbl[t].vi, tbl[t].proto, tbl[t].dip,
            32'h0A00_0000 + 32'(t), 16'(1000 + t), tbl[t].dport, tbl[t].ulen,
            tbl[t].pre, tbl[t].nbytes);
      model(tbl[t].nbytes, nw, ntr);
      send(tbl[t].nbytes, (tbl[t].nbytes + 1) / 2, tbl[t].gap, 1'b1);
      flush();
      tbl_drop += tbl[t].exp_drop;
      tr_obs = trunc_nv - nv0;
      foreach (obs_q[k]) tr_obs += int'(obs_q[k].tr);
      chk($sformatf("tbl%0d word count", t), 64'(obs_q.size()), 64'(tbl[t].exp_words));
      chk($sformatf("tbl%0d drop_cnt", t), 64'(drop_cnt), 64'(tbl_drop));
      chk($sformatf("tbl%0d trunc", t), 64'(tr_obs), 64'(tbl[t].exp_tr));
      cmp_out($sformatf("tbl%0d", t));
    end

    // Randomized frames against the model.
    for (int r = 0; r < 40; r++) begin
      nv0 = trunc_nv;
      mac   = pct(8) ? {16'($urandom), 32'($urandom)} : pct(20) ? B_MAC : L_MAC;
      et    = pct(5) ? 16'h86DD : 16'h0800;
      vi    = pct(5) ? 8'h46 : 8'h45;
      proto = pct(5) ? 8'h06 : 8'h11;
      dip   = pct(5) ? 32'($urandom) : L_IP;
      dport = pct(5) ? 16'($urandom) : L_PORT;
      ulen  = pct(5) ? 16'($urandom_range(0, 8)) : 16'($urandom_range(9, 60));
      pl    = (int'(ulen) > 8) ? int'(ulen) - 8 : 0;
      if (pct(15) && pl > 1)  nb = 42 + int'($urandom_range(1, 32'(pl - 1)));
      else if (pct(15))       nb = int'($urandom_range(20, 42));
      else                    nb = 42 + pl + int'($urandom_range(0, 12));
      gp = int'($urandom_range(0, 2));
      build(mac, et, vi, proto, dip, 32'($urandom), 16'($urandom), dport, ulen, 40'd0, nb);
      model(nb, nw, ntr);
      send(nb, (nb + 1) / 2, gp, 1'b1);
      flush();
      tr_obs = trunc_nv - nv0;
      foreach (obs_q[k]) tr_obs += int'(obs_q[k].tr);
      chk($sformatf("rnd%0d drop_cnt", r), 64'(drop_cnt), 64'(exp_drop));
      chk($sformatf("rnd%0d trunc", r), 64'(tr_obs), 64'(ntr));
      cmp_out($sformatf("rnd%0d", r));
    end

    // sop in the middle of a payload: three words out, no eop, then a new frame.
    nv0 = trunc_nv;
    build(L_MAC, 16'h0800, 8'h45, 8'h11, L_IP, 32'h0B0B_0B0B, 16'd77, L_PORT, 16'd20, 40'd0, 60);
    model(60, nw, ntr);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    send(60, 24, 0, 1'b0);
    build(L_MAC, 16'h0800, 8'h45, 8'h11, L_IP, 32'h0C0C_0C0C, 16'd88, L_PORT, 16'd15, 40'd0, 60);
    model(60, nw, ntr);
    send(60, 30, 0, 1'b1);
    flush();
    chk("sop_pld trunc pulse", 64'(trunc_nv - nv0), 64'd1);
    chk("sop_pld drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    cmp_out("sop_pld");

    // sop in the middle of a header: cut frame counted as a drop.
    build(L_MAC, 16'h0800, 8'h45, 8'h11, L_IP, 32'h0D0D_0D0D, 16'd99, L_PORT, 16'd12, 40'd0, 60);
    send(60, 10, 0, 1'b0);
    exp_drop++;
    build(B_MAC, 16'h0800, 8'h45, 8'h11, L_IP, 32'h0E0E_0E0E, 16'd55, L_PORT, 16'd16, 40'd0, 60);
    model(60, nw, ntr);
    send(60, 30, 0, 1'b1);
    flush();
    chk("sop_hdr drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    cmp_out("sop_hdr");

    // Reset in the middle of a header, then a clean frame.
    build(L_MAC, 16'h0800, 8'h45, 8'h11, L_IP, 32'h0F0F_0F0F, 16'd66, L_PORT, 16'd12, 40'd0, 60);
    send(60, 10, 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_zero("mid_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    obs_q.delete(); exp_q.delete(); exp_drop = 0;
    build(L_MAC, 16'h0800, 8'h45, 8'h11, L_IP, 32'h1010_1010, 16'd44, L_PORT, 16'd13, 40'd0, 60);
    model(60, nw, ntr);
    send(60, 30, 0, 1'b1);
    flush();
    chk("post_reset drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    cmp_out("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
